// File: rtl/rsa_decrypt.sv
// RSA decryptor: recovers an 8-bit plaintext as c^D mod N using right-to-left
// square-and-multiply, one exponent bit per cycle, with valid/ready on both sides.
module rsa_decrypt #(
    parameter int N      = 3233,
    parameter int D      = 2753,
    parameter int D_BITS = 12,
    parameter int CW     = 13,
    parameter int RW     = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_err,
    input  logic          out_ready,
    output logic          busy
);

    localparam int CNT_W = $clog2(D_BITS + 1);
    localparam int PW    = 2 * RW;

    localparam logic [PW-1:0]     N_P      = PW'(N);
    localparam logic [CW-1:0]     N_C      = CW'(N);
    localparam logic [D_BITS-1:0] D_INIT   = D_BITS'(D);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(D_BITS - 1);
    localparam logic [RW-1:0]     BYTE_MAX = RW'(255);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [RW-1:0]     r_result;
    logic [RW-1:0]     r_base;
    logic [D_BITS-1:0] r_exp;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_range;
    logic [7:0]        r_out_data;
    logic              r_out_err;

    logic [PW-1:0] w_prod_rb;
    logic [PW-1:0] w_prod_bb;
    logic [RW-1:0] w_mod_rb;
    logic [RW-1:0] w_mod_bb;
    logic [RW-1:0] w_in_mod;
    logic [RW-1:0] w_res_nxt;
    logic          w_in_range_err;
    logic          w_last;

    // Both products are kept at full width and reduced in the same cycle.
    assign w_prod_rb      = PW'(r_result) * PW'(r_base);
    assign w_prod_bb      = PW'(r_base) * PW'(r_base);
    assign w_mod_rb       = RW'(w_prod_rb % N_P);
    assign w_mod_bb       = RW'(w_prod_bb % N_P);
    assign w_in_mod       = RW'(in_data % N_C);
    assign w_in_range_err = (in_data >= N_C);
    assign w_res_nxt      = r_exp[0] ? w_mod_rb : r_result;
    assign w_last         = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result   <= RW'(1);
            r_base     <= '0;
            r_exp      <= '0;
            r_cnt      <= '0;
            r_range    <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_base   <= w_in_mod;
                        r_result <= RW'(1);
                        r_exp    <= D_INIT;
                        r_cnt    <= '0;
                        r_range  <= w_in_range_err;
                    end
                end
                S_STEP: begin
                    r_result <= w_res_nxt;
                    r_base   <= w_mod_bb;
                    r_exp    <= r_exp >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Outputs are captured from the final product so they survive the next job's init.
                    if (w_last) begin
                        r_out_data <= w_res_nxt[7:0];
                        r_out_err  <= r_range | (w_res_nxt > BYTE_MAX);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_err  = r_out_err;

endmodule

// File: tb/tb_rsa_decrypt.sv
// Directed self-checking bench for rsa_decrypt with hand-computed RSA vectors
// (N=3233, e=17, d=2753).
module tb_rsa_decrypt;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [12:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_err;
    logic        out_ready;
    logic        busy;

    int n_pass = 0;
    int n_chk  = 0;

    rsa_decrypt #(
        .N      (3233),
        .D      (2753),
        .D_BITS (12),
        .CW     (13),
        .RW     (12)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Encryptor model used only to produce ciphertexts for the end-to-end vectors.
    function automatic longint modexp(input longint b, input longint e, input longint n);
        longint r = 1;
        longint x = b % n;
        longint k = e;
        while (k > 0) begin
            if (k[0]) r = (r * x) % n;
            x = (x * x) % n;
            k = k >> 1;
        end
        return r;
    endfunction

    // Accept one word and wait for out_valid; checks latency and ready/busy during the job.
    task automatic start_and_wait(input int cin, input string tag);
        int lat;
        int wait_cnt;
        bit saw_ready;
        bit saw_idle;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        in_valid = 1'b1;
        in_data  = 13'(cin);
        tick();
        in_valid = 1'b0;
        lat       = 0;
        saw_ready = 1'b0;
        saw_idle  = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) saw_ready = 1'b1;
            if (!busy)    saw_idle  = 1'b1;
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 12);
        check({tag, "_ready_low_step"}, saw_ready, 0);
        check({tag, "_busy_step"}, saw_idle, 0);
        check({tag, "_ready_low_done"}, in_ready, 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_cleared"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic run_job(input int cin, input int exp_d, input int exp_e, input string tag);
        out_ready = 1'b1;
        start_and_wait(cin, tag);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_err"}, out_err, exp_e);
        handshake(tag);
    endtask

    initial begin
        bit stable;
        bit consumed;
        int held_d;
        int e2e_pt[4];
        int m;
        e2e_pt[0] = 0;
        e2e_pt[1] = 1;
        e2e_pt[2] = 65;
        e2e_pt[3] = 255;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        run_job(2790, 65, 0, "c2790");
        run_job(0, 0, 0, "c0");
        run_job(1, 1, 0, "c1");
        run_job(3232, 160, 1, "c3232");
        run_job(3233, 0, 1, "c3233");

        // Backpressure: result must hold for 20 cycles and a second word must be ignored.
        out_ready = 1'b0;
        start_and_wait(2790, "bp");
        held_d   = out_data;
        stable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 13'd1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid || out_data != 8'd65 || out_err) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_data", held_d, 65);
        check("bp_stable", stable, 1);
        handshake("bp");
        consumed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) consumed = 1'b1;
        end
        check("bp_word_ignored", consumed, 0);

        // Reset mid-STEP discards the job.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 13'd2790;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        run_job(2790, 65, 0, "post_rst");

        for (int i = 0; i < 4; i++) begin
            m = e2e_pt[i];
            run_job(int'(modexp(m, 17, 3233)), m, 0, $sformatf("e2e_%0d", m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt.md
Name: rsa_decrypt

Overview:
- Downstream consumer of the RSA encrypt datapath's 13-bit `output_data` ciphertext.
- Recovers the original 8-bit plaintext by modular exponentiation c^D mod N, using right-to-left square-and-multiply with one exponent bit per cycle.
- Valid/ready handshake on both sides, so it can sit between the encryptor and a byte sink with backpressure.

Parameters:
- N, 3233: RSA modulus. Must match the encryptor's n.
- D, 2753: private exponent.
- D_BITS, 12: number of exponent bits processed. D must be < 2^D_BITS.
- CW, 13: ciphertext input width.
- RW, 12: width of the internal residue registers. Must satisfy N <= 2^RW.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext present on in_data.
- in_data  in  CW  ciphertext word.
- in_ready  out  1  block can accept a ciphertext; high only in IDLE.
- out_valid  out  1  plaintext result available.
- out_data  out  8  recovered plaintext, equal to result[7:0].
- out_err  out  1  input was >= N, or the recovered result is > 255.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in STEP or DONE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - out_valid=0, out_data=0, out_err=0, busy=0.
  - Internal result=1, base=0, exp=0, bit counter=0, range flag=0.
  - Reset overrides all other inputs in the same cycle.
  - Reset mid-STEP or mid-DONE discards the job; no output is produced.
- States: IDLE, STEP, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the word is accepted:
    - base <= in_data mod N.
    - result <= 1.
    - exp <= D.
    - counter <= 0.
    - range flag <= (in_data >= N).
    - state -> STEP.
- STEP (one exponent bit per cycle):
  - If exp[0]=1: result <= (result*base) mod N. Otherwise result is held.
  - base <= (base*base) mod N.
  - exp <= exp >> 1.
  - counter++.
  - When counter == D_BITS-1 on this edge, state -> DONE on the same edge, and out_valid becomes 1.
- Arithmetic: both products are full 2*RW-bit unsigned values, reduced mod N combinationally within the same cycle. The two multiplies run in parallel; no product is truncated before the reduction.
- Latency: if accepted at edge k, out_valid is high after edge k+D_BITS (12 cycles by default). The latency is fixed and independent of the data value.
- DONE:
  - out_data = result[7:0].
  - out_err = range flag OR (result > 255).
  - out_valid, out_data and out_err hold stable while out_ready=0, for an unbounded time.
  - On an edge with out_ready=1: out_valid <= 0, state -> IDLE.
  - in_ready stays low in DONE, so at least one idle cycle separates consecutive jobs.
- in_valid while not in IDLE: ignored. The word is not captured and there is no error.
- in_data = 0: the result is 0, because exp includes bit 0 (D is odd) and base=0.
- out_data/out_err after a handshake: hold their last values with out_valid=0 until the next job finishes. Consumers must qualify them with out_valid.

Test Plan:
- Reset, then in_data=2790 with in_valid pulsed and out_ready=1 -> out_valid rises exactly 12 cycles after the accept edge; out_data=65 (0x41), out_err=0.
- in_data=0 -> out_data=0, out_err=0. Then in_data=1 -> out_data=1, out_err=0. Confirm in_ready=0 throughout STEP and DONE.
- in_data=3232 -> result 3232 (since -1^odd mod N is N-1); out_data=0xA0 (160), out_err=1. Then in_data=3233 (>= N, reduces to 0) -> out_data=0, out_err=1.
- Backpressure: job with in_data=2790 and out_ready held low 20 cycles -> out_valid=1 and out_data=65 stable all 20 cycles. in_valid asserted with another word during this window is not consumed. Raising out_ready -> one-cycle handshake, then in_ready returns high the next cycle.
- Reset mid-operation: assert reset 5 cycles after accepting 2790 -> next cycle state IDLE, out_valid=0, in_ready=1. Then a fresh 2790 job -> out_data=65 with full 12-cycle latency.
- End-to-end: chain the encrypt datapath output for plaintext bytes 0, 1, 65, 255 into this block -> each out_data equals the original byte, out_err=0.
